sha256_job_scheduler: RTL and testbench

Round-robin job scheduler that shares one simplified SHA-256 hashing core among `NUM_REQ` requesters. Each requester posts a message address and an output address. The scheduler grants one job at a time, launches the core, tracks the core's busy/idle handshake, and returns a per-requester completion pulse. It sits between the requesting masters and the core's `start`/`message_addr`/`output_addr`/`done` pins. It does not touch the memory bus.

---
 rtl/sha256_job_scheduler.sv | 199 +++++++++++++++++++
 tb/tb_sha256_job_scheduler.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_job_scheduler.sv
// sha256_job_scheduler
// Round-robin arbiter that shares one SHA-256 core among NUM_REQ requesters.
// Grants one job at a time, launches the core and follows its done handshake.
// When the job ends it returns a one-cycle completion pulse to the requester that owned it.
//
// Optional feature: define SHA_SCHED_WATCHDOG_EN to compile in a watchdog.
// The watchdog aborts a job after WDOG_CYCLES cycles and reports it with err.
//
// Ports:
//   clk, reset_n            clock, synchronous active-low reset
//   req[NUM_REQ]            level job requests
//   req_msg_addr/out_addr   16-bit addresses per requester, slice k = requester k
//   grant[NUM_REQ]          one-cycle pulse, job accepted and addresses latched
//   cmpl[NUM_REQ]           one-cycle pulse, job finished
//   err                     high with cmpl when the watchdog aborted the job
//   busy                    high from the grant cycle through the cmpl cycle
//   core_start              one-cycle start pulse to the core
//   core_message_addr/core_output_addr  latched job addresses
//   core_done               core idle flag
module sha256_job_scheduler #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned WDOG_CYCLES = 4096
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [16*NUM_REQ-1:0]   req_msg_addr,
    input  logic [16*NUM_REQ-1:0]   req_out_addr,
    output logic [NUM_REQ-1:0]      grant,
    output logic [NUM_REQ-1:0]      cmpl,
    output logic                    err,
    output logic                    busy,
    output logic                    core_start,
    output logic [15:0]             core_message_addr,
    output logic [15:0]             core_output_addr,
    input  logic                    core_done
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE,
        COMPLETE
    } state_t;

    state_t             state, state_nxt;
    logic [PTR_W-1:0]   rr_ptr, rr_ptr_nxt;
    logic [PTR_W-1:0]   owner, owner_nxt;
    logic [NUM_REQ-1:0] grant_nxt, cmpl_nxt;
    logic               err_nxt, busy_nxt, start_nxt;
    logic [15:0]        msg_nxt, out_nxt;

    logic               pick_found;
    logic [PTR_W-1:0]   pick_idx;
    logic [PTR_W-1:0]   cand;

    logic [15:0]        msg_arr [NUM_REQ];
    logic [15:0]        out_arr [NUM_REQ];

    // Unpack the flat address buses into per-requester words.
    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign msg_arr[k] = req_msg_addr[16*k +: 16];
        assign out_arr[k] = req_out_addr[16*k +: 16];
    end

    // First set request at or above rr_ptr, wrapping around.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = PTR_W'((32'(rr_ptr) + i) % NUM_REQ);
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

`ifdef SHA_SCHED_WATCHDOG_EN
    localparam int unsigned WD_W = $clog2(WDOG_CYCLES + 1);
    logic [WD_W-1:0] wdog_cnt, wdog_nxt;
    logic            wdog_hit;
    assign wdog_hit = (wdog_cnt == WD_W'(WDOG_CYCLES));
`else
    logic unused_wdog;
    assign unused_wdog = ^32'(WDOG_CYCLES);
`endif

    // Next-state and next-output logic.
    always_comb begin
        state_nxt  = state;
        rr_ptr_nxt = rr_ptr;
        owner_nxt  = owner;
        grant_nxt  = '0;
        cmpl_nxt   = '0;
        err_nxt    = 1'b0;
        start_nxt  = 1'b0;
        busy_nxt   = busy;
        msg_nxt    = core_message_addr;
        out_nxt    = core_output_addr;
`ifdef SHA_SCHED_WATCHDOG_EN
        wdog_nxt   = wdog_cnt;
`endif
        case (state)
            IDLE: begin
                busy_nxt = 1'b0;
                // A low core_done means the core is in use externally.
                if (pick_found && core_done) begin
                    owner_nxt           = pick_idx;
                    grant_nxt[pick_idx] = 1'b1;
                    msg_nxt             = msg_arr[pick_idx];
                    out_nxt             = out_arr[pick_idx];
                    busy_nxt            = 1'b1;
                    state_nxt           = LAUNCH;
                end
            end
            LAUNCH: begin
                start_nxt = 1'b1;
                state_nxt = WAIT_BUSY;
`ifdef SHA_SCHED_WATCHDOG_EN
                wdog_nxt  = '0;
`endif
            end
            WAIT_BUSY: begin
`ifdef SHA_SCHED_WATCHDOG_EN
                if (wdog_hit) begin
                    state_nxt = COMPLETE;
                end else begin
                    wdog_nxt = wdog_cnt + WD_W'(1);
                    if (!core_done) state_nxt = WAIT_DONE;
                end
`else
                if (!core_done) state_nxt = WAIT_DONE;
`endif
            end
            WAIT_DONE: begin
`ifdef SHA_SCHED_WATCHDOG_EN
                // The counter freezes below the limit on a normal finish, so wdog_hit is true in COMPLETE only after an abort.
                if (wdog_hit || core_done) begin
                    state_nxt = COMPLETE;
                end else begin
                    wdog_nxt = wdog_cnt + WD_W'(1);
                end
`else
                if (core_done) state_nxt = COMPLETE;
`endif
            end
            COMPLETE: begin
                cmpl_nxt[owner] = 1'b1;
`ifdef SHA_SCHED_WATCHDOG_EN
                err_nxt         = wdog_hit;
`endif
                busy_nxt        = 1'b1;
                rr_ptr_nxt      = (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + PTR_W'(1);
                state_nxt       = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state             <= IDLE;
            rr_ptr            <= '0;
            owner             <= '0;
            grant             <= '0;
            cmpl              <= '0;
            err               <= 1'b0;
            busy              <= 1'b0;
            core_start        <= 1'b0;
            core_message_addr <= '0;
            core_output_addr  <= '0;
        end else begin
            state             <= state_nxt;
            rr_ptr            <= rr_ptr_nxt;
            owner             <= owner_nxt;
            grant             <= grant_nxt;
            cmpl              <= cmpl_nxt;
            err               <= err_nxt;
            busy              <= busy_nxt;
            core_start        <= start_nxt;
            core_message_addr <= msg_nxt;
            core_output_addr  <= out_nxt;
        end
    end

`ifdef SHA_SCHED_WATCHDOG_EN
    always_ff @(posedge clk) begin
        if (!reset_n) wdog_cnt <= '0;
        else          wdog_cnt <= wdog_nxt;
    end
`endif

endmodule

// File: tb/tb_sha256_job_scheduler.sv
// Directed testbench for sha256_job_scheduler with a small behavioural core model.
module tb_sha256_job_scheduler;

`ifdef SHA_SCHED_WATCHDOG_EN
    localparam int unsigned WDOG       = 16;
    localparam int          SINGLE_RUN = 10;
`else
    localparam int unsigned WDOG       = 4096;
    localparam int          SINGLE_RUN = 198;
`endif

    logic        clk;
    logic        reset_n;
    logic [3:0]  req;
    logic [63:0] req_msg_addr;
    logic [63:0] req_out_addr;
    logic [3:0]  grant;
    logic [3:0]  cmpl;
    logic        err;
    logic        busy;
    logic        core_start;
    logic [15:0] core_message_addr;
    logic [15:0] core_output_addr;
    logic        core_done;

    logic        model_en;
    logic        model_drop;
    logic        model_done;
    logic        tb_done;
    int          run_len;

    int          n_vec;
    int          n_bad;
    logic [15:0] exp_msg [4];
    logic [15:0] exp_out [4];

    assign core_done = model_en ? model_done : tb_done;

    sha256_job_scheduler #(.NUM_REQ(4), .WDOG_CYCLES(WDOG)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .req               (req),
        .req_msg_addr      (req_msg_addr),
        .req_out_addr      (req_out_addr),
        .grant             (grant),
        .cmpl              (cmpl),
        .err               (err),
        .busy              (busy),
        .core_start        (core_start),
        .core_message_addr (core_message_addr),
        .core_output_addr  (core_output_addr),
        .core_done         (core_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Core model: on a start pulse, drop done and raise it run_len cycles later.
    initial begin
        model_done = 1'b1;
        forever begin
            @(negedge clk);
            if (model_en && model_drop && core_start) begin
                model_done = 1'b0;
                repeat (run_len) @(negedge clk);
                model_done = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        req        = 4'b0000;
        model_en   = 1'b1;
        model_drop = 1'b1;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic wait_grant(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            tick();
            if (grant !== 4'b0000) ok = 1'b1;
        end
    endtask

    task automatic wait_cmpl(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            tick();
            if (cmpl !== 4'b0000) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        req     = 4'b1111;
        tick();
        n_vec++; if (grant !== 4'b0000) begin n_bad++; $display("FAIL reset_grant: got %b want 0000", grant); end
        n_vec++; if (cmpl !== 4'b0000) begin n_bad++; $display("FAIL reset_cmpl: got %b want 0000", cmpl); end
        n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_vec++; if (core_start !== 1'b0) begin n_bad++; $display("FAIL reset_start: got %b want 0", core_start); end
        n_vec++; if (core_message_addr !== 16'h0000) begin n_bad++; $display("FAIL reset_msg: got %h want 0000", core_message_addr); end
        n_vec++; if (core_output_addr !== 16'h0000) begin n_bad++; $display("FAIL reset_out: got %h want 0000", core_output_addr); end
        tick();
        n_vec++; if (grant !== 4'b0000) begin n_bad++; $display("FAIL reset_hold_grant: got %b want 0000", grant); end
        req     = 4'b0000;
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_single_job();
        int   cmpl_cyc;
        logic [3:0] cmpl_val;
        logic err_val, busy_at_cmpl, busy_after;
        do_reset();
        run_len      = SINGLE_RUN;
        cmpl_cyc     = -1;
        cmpl_val     = 4'b0000;
        err_val      = 1'b0;
        busy_at_cmpl = 1'b0;
        busy_after   = 1'b1;
        req = 4'b0001;
        for (int i = 1; i <= SINGLE_RUN + 10; i++) begin
            tick();
            if (i == 1) begin
                n_vec++; if (grant !== 4'b0001) begin n_bad++; $display("FAIL single_grant: got %b want 0001", grant); end
                n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy_grant: got %b want 1", busy); end
                req = 4'b0000;
            end
            if (i == 2) begin
                n_vec++; if (core_start !== 1'b1) begin n_bad++; $display("FAIL single_start: got %b want 1", core_start); end
                n_vec++; if (core_message_addr !== 16'h0000) begin n_bad++; $display("FAIL single_msg: got %h want 0000", core_message_addr); end
                n_vec++; if (core_output_addr !== 16'h0100) begin n_bad++; $display("FAIL single_out: got %h want 0100", core_output_addr); end
            end
            if (i == 3) begin
                n_vec++; if (core_start !== 1'b0) begin n_bad++; $display("FAIL single_start_len: got %b want 0", core_start); end
            end
            if (cmpl !== 4'b0000 && cmpl_cyc < 0) begin
                cmpl_cyc     = i;
                cmpl_val     = cmpl;
                err_val      = err;
                busy_at_cmpl = busy;
            end
            if (i == SINGLE_RUN + 5) busy_after = busy;
        end
        n_vec++; if (cmpl_cyc != SINGLE_RUN + 4) begin n_bad++; $display("FAIL single_cmpl_cycle: got %0d want %0d", cmpl_cyc, SINGLE_RUN + 4); end
        n_vec++; if (cmpl_val !== 4'b0001) begin n_bad++; $display("FAIL single_cmpl_val: got %b want 0001", cmpl_val); end
        n_vec++; if (err_val !== 1'b0) begin n_bad++; $display("FAIL single_err: got %b want 0", err_val); end
        n_vec++; if (busy_at_cmpl !== 1'b1) begin n_bad++; $display("FAIL single_busy_cmpl: got %b want 1", busy_at_cmpl); end
        n_vec++; if (busy_after !== 1'b0) begin n_bad++; $display("FAIL single_busy_after: got %b want 0", busy_after); end
    endtask

    task automatic test_simultaneous();
        int ord [4];
        int ng, nc, cur;
        bit pend;
        do_reset();
        run_len = 5;
        ng = 0; nc = 0; cur = 0; pend = 1'b0;
        for (int k = 0; k < 4; k++) ord[k] = -1;
        req = 4'b1111;
        for (int i = 0; i < 400 && nc < 4; i++) begin
            tick();
            if (grant !== 4'b0000) begin
                n_vec++; if (pend) begin n_bad++; $display("FAIL simul_grant_before_cmpl: got grant %b want none", grant); end
                for (int k = 0; k < 4; k++) if (grant[k]) cur = k;
                if (ng < 4) ord[ng] = cur;
                ng++;
                req  = req & ~grant;
                pend = 1'b1;
            end
            if (core_start === 1'b1) begin
                n_vec++; if (core_message_addr !== exp_msg[cur]) begin n_bad++; $display("FAIL simul_msg%0d: got %h want %h", cur, core_message_addr, exp_msg[cur]); end
                n_vec++; if (core_output_addr !== exp_out[cur]) begin n_bad++; $display("FAIL simul_out%0d: got %h want %h", cur, core_output_addr, exp_out[cur]); end
            end
            if (cmpl !== 4'b0000) begin
                n_vec++; if (cmpl !== (4'b0001 << cur)) begin n_bad++; $display("FAIL simul_cmpl: got %b want %b", cmpl, 4'b0001 << cur); end
                pend = 1'b0;
                nc++;
            end
        end
        n_vec++; if (nc != 4) begin n_bad++; $display("FAIL simul_timeout: got %0d cmpl want 4", nc); end
        for (int k = 0; k < 4; k++) begin
            n_vec++; if (ord[k] != k) begin n_bad++; $display("FAIL simul_order%0d: got %0d want %0d", k, ord[k], k); end
        end
        tick();
    endtask

    task automatic test_fairness();
        int exp_seq [4];
        int seq [4];
        int ng;
        bit ok;
        exp_seq = '{0, 2, 0, 2};
        do_reset();
        run_len = 5;
        ng = 0;
        for (int k = 0; k < 4; k++) seq[k] = -1;
        req = 4'b0101;
        for (int i = 0; i < 400 && ng < 4; i++) begin
            tick();
            if (grant !== 4'b0000) begin
                for (int k = 0; k < 4; k++) if (grant[k]) seq[ng] = k;
                ng++;
            end
        end
        req = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            n_vec++; if (seq[k] != exp_seq[k]) begin n_bad++; $display("FAIL fair_seq%0d: got %0d want %0d", k, seq[k], exp_seq[k]); end
        end
        wait_cmpl(ok);
        n_vec++; if (!ok) begin n_bad++; $display("FAIL fair_last_cmpl: got timeout want cmpl"); end
        tick();
    endtask

    task automatic test_external();
        int seen;
        bit ok;
        do_reset();
        run_len  = 5;
        model_en = 1'b0;
        tb_done  = 1'b0;
        seen     = 0;
        req      = 4'b0010;
        repeat (10) begin
            tick();
            if (grant !== 4'b0000) seen++;
        end
        n_vec++; if (seen != 0) begin n_bad++; $display("FAIL ext_no_grant: got %0d grants want 0", seen); end
        tb_done = 1'b1;
        tick();
        n_vec++; if (grant !== 4'b0010) begin n_bad++; $display("FAIL ext_grant: got %b want 0010", grant); end
        req      = 4'b0000;
        model_en = 1'b1;
        wait_cmpl(ok);
        n_vec++; if (!ok || cmpl !== 4'b0010) begin n_bad++; $display("FAIL ext_cmpl: got %b want 0010", cmpl); end
        n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL ext_err: got %b want 0", err); end
        tick();
    endtask

    task automatic test_reset_mid_job();
        bit ok;
        int ncmpl, ngrant;
        do_reset();
        run_len = 5;
        req = 4'b0010;
        wait_grant(ok);
        req = 4'b0000;
        wait_cmpl(ok);
        n_vec++; if (!ok) begin n_bad++; $display("FAIL rst_pre_job: got timeout want cmpl"); end
        tick();
        // Next pointer is now 2; the lost job belongs to requester 2.
        run_len = 40;
        req = 4'b0100;
        wait_grant(ok);
        req = 4'b0000;
        n_vec++; if (!ok || grant !== 4'b0100) begin n_bad++; $display("FAIL rst_grant2: got %b want 0100", grant); end
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            if (core_done === 1'b0) ok = 1'b1;
        end
        n_vec++; if (!ok) begin n_bad++; $display("FAIL rst_core_busy: got timeout want done low"); end
        tick(); tick(); tick();
        reset_n = 1'b0;
        tick();
        n_vec++; if ({grant, cmpl, err, busy, core_start} !== 11'd0) begin n_bad++; $display("FAIL rst_mid_ctrl: got %b want 0", {grant, cmpl, err, busy, core_start}); end
        n_vec++; if ({core_message_addr, core_output_addr} !== 32'd0) begin n_bad++; $display("FAIL rst_mid_addr: got %h want 0", {core_message_addr, core_output_addr}); end
        reset_n = 1'b1;
        ncmpl = 0; ngrant = 0;
        repeat (60) begin
            tick();
            if (cmpl !== 4'b0000) ncmpl++;
            if (grant !== 4'b0000) ngrant++;
        end
        n_vec++; if (ncmpl != 0) begin n_bad++; $display("FAIL rst_lost_cmpl: got %0d want 0", ncmpl); end
        n_vec++; if (ngrant != 0) begin n_bad++; $display("FAIL rst_spurious_grant: got %0d want 0", ngrant); end
        run_len = 5;
        req = 4'b0101;
        wait_grant(ok);
        req = 4'b0000;
        n_vec++; if (!ok || grant !== 4'b0001) begin n_bad++; $display("FAIL rst_ptr_zero: got %b want 0001", grant); end
        wait_cmpl(ok);
        n_vec++; if (!ok || cmpl !== 4'b0001) begin n_bad++; $display("FAIL rst_after_cmpl: got %b want 0001", cmpl); end
        tick();
    endtask

`ifdef SHA_SCHED_WATCHDOG_EN
    task automatic test_watchdog();
        bit ok;
        int k;
        do_reset();
        model_drop = 1'b0;
        req = 4'b0010;
        wait_grant(ok);
        req = 4'b0000;
        tick();
        n_vec++; if (core_start !== 1'b1) begin n_bad++; $display("FAIL wdog_start: got %b want 1", core_start); end
        k = 0;
        while (cmpl === 4'b0000 && k < 100) begin
            tick();
            k++;
        end
        n_vec++; if (k != 18) begin n_bad++; $display("FAIL wdog_latency: got %0d want 18", k); end
        n_vec++; if (cmpl !== 4'b0010) begin n_bad++; $display("FAIL wdog_cmpl: got %b want 0010", cmpl); end
        n_vec++; if (err !== 1'b1) begin n_bad++; $display("FAIL wdog_err: got %b want 1", err); end
        model_drop = 1'b1;
        tick();
    endtask
`endif

    initial begin
        n_vec      = 0;
        n_bad      = 0;
        reset_n    = 1'b0;
        req        = 4'b0000;
        model_en   = 1'b1;
        model_drop = 1'b1;
        tb_done    = 1'b1;
        run_len    = 5;
        req_msg_addr = {16'h3300, 16'h2200, 16'h1100, 16'h0000};
        req_out_addr = {16'h3310, 16'h2210, 16'h1110, 16'h0100};
        exp_msg = '{16'h0000, 16'h1100, 16'h2200, 16'h3300};
        exp_out = '{16'h0100, 16'h1110, 16'h2210, 16'h3310};

        test_reset();
        test_single_job();
        test_simultaneous();
        test_fairness();
        test_external();
        test_reset_mid_job();
`ifdef SHA_SCHED_WATCHDOG_EN
        test_watchdog();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
